// File: rtl/reg_delay_pkg.sv
// Shared definitions for the runtime-programmable gated delay line.
//   state_e  : fill/run state of the output path
//   DelayAw  : default address width (buffer depth 2**DelayAw)
//   MaxDelay : largest legal delay for the default address width
package reg_delay_pkg;

  localparam int unsigned DelayAw  = 6;
  localparam int unsigned MaxDelay = (1 << DelayAw) - 1;

  typedef enum logic {
    StFill = 1'b0,
    StRun  = 1'b1
  } state_e;

endpackage

// File: rtl/reg_delay_ram.sv
// Simple dual-port RAM, Dw x 2**Aw, registered read, no reset.
//   clk_i   : clock
//   we_i    : write enable, waddr_i / wdata_i : write port
//   re_i    : read enable, raddr_i : read address
//   rdata_o : registered read data, holds while re_i is low
module reg_delay_ram #(
  parameter int unsigned Dw = 16,
  parameter int unsigned Aw = 6
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [Aw-1:0] waddr_i,
  input  logic [Dw-1:0] wdata_i,
  input  logic          re_i,
  input  logic [Aw-1:0] raddr_i,
  output logic [Dw-1:0] rdata_o
);

  localparam int unsigned Depth = 1 << Aw;

  logic [Dw-1:0] mem_q [Depth];
  logic [Dw-1:0] rdata_q;

  // Read-first; the caller never reads the address being written.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/reg_delay_rd.sv
// Gated delay line with a runtime-programmable delay.
// A circular buffer stores one sample per gated cycle; the read pointer trails
// the write pointer by the registered delay. Output is zero and invalid until
// enough samples have been gathered for the current delay.
//   clk        : clock
//   reset_n    : asynchronous active-low reset
//   clr        : synchronous clear (memory untouched)
//   gate       : sample enable
//   din        : input data
//   delay      : requested delay in gated cycles (0 = combinational bypass)
//   dout       : delayed data
//   dout_valid : dout is a true delayed sample for the current delay
module reg_delay_rd
  import reg_delay_pkg::*;
#(
  parameter int unsigned dw = 16,
  parameter int unsigned aw = DelayAw
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          gate,
  input  logic [dw-1:0] din,
  input  logic [aw-1:0] delay,
  output logic [dw-1:0] dout,
  output logic          dout_valid
);

  state_e        state_q, state_d;
  logic [aw-1:0] wptr_q, wptr_d;
  logic [aw-1:0] fill_q, fill_d;
  logic [aw-1:0] delay_r_q, delay_r_d;
  logic          valid_q, valid_d;
  logic [dw-1:0] byp_q, byp_d;
  logic          use_byp_q, use_byp_d;

  logic          dly_chg;
  logic          we;
  logic          re;
  logic [aw-1:0] raddr;
  logic [dw-1:0] ram_rdata;
  logic          pass;

  assign dly_chg = (delay != delay_r_q);
  // A write happens on every accepted gated cycle unless the (new) delay is 0.
  assign we      = gate & ~clr & (delay != '0);
  // D=1 is served from the bypass register, so the RAM is only read for D>=2,
  // which keeps raddr away from wptr.
  assign re      = gate & ~clr & (delay_r_q > aw'(1));
  assign raddr   = wptr_q - delay_r_q + aw'(1);

  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    fill_d    = fill_q;
    delay_r_d = delay;
    valid_d   = valid_q;
    byp_d     = byp_q;
    use_byp_d = use_byp_q;

    if (clr) begin
      state_d   = StFill;
      wptr_d    = '0;
      fill_d    = '0;
      delay_r_d = '0;
      valid_d   = 1'b0;
      use_byp_d = 1'b0;
    end else if (dly_chg) begin
      // Restart for the new delay; a gated sample this cycle is fill sample 1.
      valid_d   = 1'b0;
      use_byp_d = 1'b0;
      if (delay == '0) begin
        state_d = StRun;
        fill_d  = '0;
      end else if (gate) begin
        wptr_d = wptr_q + aw'(1);
        byp_d  = din;
        fill_d = aw'(1);
        if (delay == aw'(1)) begin
          state_d   = StRun;
          valid_d   = 1'b1;
          use_byp_d = 1'b1;
        end else begin
          state_d = StFill;
        end
      end else begin
        state_d = StFill;
        fill_d  = '0;
      end
    end else if (delay_r_q == '0) begin
      state_d = StRun;
      valid_d = 1'b0;
    end else if (gate) begin
      wptr_d    = wptr_q + aw'(1);
      byp_d     = din;
      use_byp_d = (delay_r_q == aw'(1));
      if (state_q == StFill) begin
        if (fill_q == delay_r_q - aw'(1)) begin
          state_d = StRun;
          fill_d  = delay_r_q;
          valid_d = 1'b1;
        end else begin
          fill_d  = fill_q + aw'(1);
          valid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StFill;
      wptr_q    <= '0;
      fill_q    <= '0;
      delay_r_q <= '0;
      valid_q   <= 1'b0;
      byp_q     <= '0;
      use_byp_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      fill_q    <= fill_d;
      delay_r_q <= delay_r_d;
      valid_q   <= valid_d;
      byp_q     <= byp_d;
      use_byp_q <= use_byp_d;
    end
  end

  reg_delay_ram #(
    .Dw (dw),
    .Aw (aw)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (we),
    .waddr_i (wptr_q),
    .wdata_i (din),
    .re_i    (re),
    .raddr_i (raddr),
    .rdata_o (ram_rdata)
  );

  // Output register stage is split between the RAM read register and the
  // bypass register; valid_q masks both so reset/clear/fill read as zero.
  assign pass = (state_q == StRun) && (delay_r_q == '0);

  always_comb begin
    dout = '0;
    if (pass) begin
      dout = din;
    end else if (valid_q) begin
      dout = use_byp_q ? byp_q : ram_rdata;
    end
  end

  assign dout_valid = pass | valid_q;

endmodule

// File: tb/tb_reg_delay_rd.sv
module tb_reg_delay_rd;

  localparam int unsigned Dw = 16;
  localparam int unsigned Aw = 6;

  logic          clk;
  logic          reset_n;
  logic          clr;
  logic          gate;
  logic [Dw-1:0] din;
  logic [Aw-1:0] delay;
  logic [Dw-1:0] dout;
  logic          dout_valid;

  int checks = 0;
  int errors = 0;

  bit            t2_gate [7] = '{1, 0, 0, 1, 1, 0, 1};
  bit            t2_val  [7] = '{0, 0, 0, 0, 1, 1, 1};
  logic [Dw-1:0] t2_dout [7] = '{0, 0, 0, 0, 10, 10, 13};

  reg_delay_rd #(
    .dw (Dw),
    .aw (Aw)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr        (clr),
    .gate       (gate),
    .din        (din),
    .delay      (delay),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [Dw-1:0] got, input logic [Dw-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic [Dw-1:0] ed);
    chk({tag, " valid"}, Dw'(dout_valid), Dw'(ev));
    chk({tag, " dout"}, dout, ed);
  endtask

  initial begin
    // Reset state
    reset_n = 1'b0;
    clr     = 1'b0;
    gate    = 1'b1;
    din     = 16'd1;
    delay   = 6'd4;
    #1;
    chk_out("reset", 1'b0, '0);
    #2;
    reset_n = 1'b1;

    // 1: delay 4, continuous gate
    for (int n = 1; n <= 8; n++) begin
      din = Dw'(n);
      tick();
      chk_out($sformatf("t1 edge%0d", n), n >= 4, (n >= 4) ? Dw'(n - 3) : '0);
    end

    // 2: delay 3 with a sparse gate
    gate  = 1'b0;
    clr   = 1'b1;
    delay = 6'd3;
    tick();
    clr = 1'b0;
    chk_out("t2 clr", 1'b0, '0);
    for (int k = 0; k < 7; k++) begin
      gate = t2_gate[k];
      din  = Dw'(10 + k);
      tick();
      chk_out($sformatf("t2 step%0d", k), t2_val[k], t2_dout[k]);
    end

    // 3: delay 5 -> 2 together with a gated sample
    gate = 1'b0;
    clr  = 1'b1;
    tick();
    clr   = 1'b0;
    delay = 6'd5;
    gate  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      din = Dw'(40 + k);
      tick();
    end
    chk_out("t3 run5", 1'b1, 16'd41);
    delay = 6'd2;
    din   = 16'd50;
    tick();
    chk_out("t3 change", 1'b0, '0);
    din = 16'd51;
    tick();
    chk_out("t3 refill", 1'b1, 16'd50);
    din = 16'd52;
    tick();
    chk_out("t3 next", 1'b1, 16'd51);

    // 4: delay 0 passthrough, then delay 1
    delay = 6'd0;
    gate  = 1'b0;
    din   = 16'h0000;
    tick();
    din = 16'hABCD;
    #1;
    chk_out("t4 pass", 1'b1, 16'hABCD);
    delay = 6'd1;
    gate  = 1'b1;
    din   = 16'h1234;
    tick();
    chk_out("t4 d1", 1'b1, 16'h1234);
    gate = 1'b0;
    din  = 16'h5555;
    tick();
    chk_out("t4 hold", 1'b1, 16'h1234);
    gate = 1'b1;
    din  = 16'h7777;
    tick();
    chk_out("t4 d1 next", 1'b1, 16'h7777);

    // 5: maximum delay across pointer wrap
    gate = 1'b0;
    clr  = 1'b1;
    tick();
    clr   = 1'b0;
    delay = 6'd63;
    gate  = 1'b1;
    for (int i = 0; i < 200; i++) begin
      din = Dw'(i);
      tick();
      chk_out($sformatf("t5 i%0d", i), i >= 62, (i >= 62) ? Dw'(i - 62) : '0);
    end

    // 6: clr with gate, then asynchronous reset between edges
    delay = 6'd4;
    for (int k = 0; k < 6; k++) begin
      din = Dw'(100 + k);
      tick();
      chk_out($sformatf("t6 run%0d", k), k >= 3, (k >= 3) ? Dw'(100 + k - 3) : '0);
    end
    clr = 1'b1;
    din = 16'd200;
    tick();
    clr = 1'b0;
    chk_out("t6 clr", 1'b0, '0);
    for (int k = 0; k < 4; k++) begin
      din = Dw'(201 + k);
      tick();
      chk_out($sformatf("t6 refill%0d", k), k == 3, (k == 3) ? 16'd201 : '0);
    end
    #2;
    reset_n = 1'b0;
    #1;
    chk_out("t6 async rst", 1'b0, '0);
    #10;
    reset_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
